// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-write, multi-read register file.
// Write requests are carried in a fixed-width struct and narrowed at use.
package reg_file_pkg;

    localparam int DefDataWidth  = 32;
    localparam int DefNumRegs    = 32;
    localparam int DefNumWrPorts = 2;
    localparam int DefNumRdPorts = 2;

    localparam int MaxAddrW = 16;
    localparam int MaxDataW = 64;
    localparam int MaxPorts = 32;

    typedef struct packed {
        logic                en;
        logic [MaxAddrW-1:0] addr;
        logic [MaxDataW-1:0] data;
    } wr_req_t;

    // Highest set bit wins; -1 when nothing hits.
    function automatic int win_port(input logic [MaxPorts-1:0] hits);
        win_port = -1;
        for (int p = 0; p < MaxPorts; p++) begin
            if (hits[p]) win_port = p;
        end
    endfunction

endpackage

// File: rtl/reg_file_mwmr_if.sv
// Write/read bus of the register file, including the synchronous clear.
// The master drives writes and read addresses; the slave returns data.
interface reg_file_mwmr_if #(
    parameter int DataWidth  = 32,
    parameter int NumRegs    = 32,
    parameter int NumWrPorts = 2,
    parameter int NumRdPorts = 2
);
    localparam int NumRegsWidth = $clog2(NumRegs);

    logic                                     clr_i;
    logic [NumWrPorts-1:0]                    wr_en_i;
    logic [NumWrPorts-1:0][NumRegsWidth-1:0]  wr_addr_i;
    logic [NumWrPorts-1:0][DataWidth-1:0]     wr_data_i;
    logic [NumRdPorts-1:0][NumRegsWidth-1:0]  rd_addr_i;
    logic [NumRdPorts-1:0][DataWidth-1:0]     rd_data_o;
    logic [NumRdPorts-1:0]                    rd_valid_o;
    logic [NumRegs-1:0]                       valid_o;

    modport master (
        output clr_i, wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
        input  rd_data_o, rd_valid_o, valid_o
    );

    modport slave (
        input  clr_i, wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
        output rd_data_o, rd_valid_o, valid_o
    );

endinterface

// File: rtl/reg_file_wr_sel.sv
// Per-register priority select over the write ports.
// The highest-indexed enabled port addressing a register wins.
module reg_file_wr_sel
    import reg_file_pkg::*;
#(
    parameter int DataWidth  = DefDataWidth,
    parameter int NumRegs    = DefNumRegs,
    parameter int NumWrPorts = DefNumWrPorts
) (
    input  wr_req_t                           req [NumWrPorts],
    output logic [NumRegs-1:0]                we,
    output logic [NumRegs-1:0][DataWidth-1:0] wdata
);

    always_comb begin : sel
        logic [MaxPorts-1:0] hits;
        int                  w;
        we    = '0;
        wdata = '0;
        for (int r = 0; r < NumRegs; r++) begin
            hits = '0;
            for (int p = 0; p < NumWrPorts; p++) begin
                hits[p] = req[p].en && (req[p].addr == MaxAddrW'(r));
            end
            w = win_port(hits);
            we[r] = (w >= 0);
            for (int p = 0; p < NumWrPorts; p++) begin
                if (p == w) wdata[r] = req[p].data[DataWidth-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_file_mwmr.sv
// Multi-write, multi-read register file with valid tracking.
// Same-cycle write-to-read forwarding under REG_FILE_WR_BYPASS_EN.
module reg_file_mwmr
    import reg_file_pkg::*;
#(
    parameter int DataWidth  = DefDataWidth,
    parameter int NumRegs    = DefNumRegs,
    parameter int NumWrPorts = DefNumWrPorts,
    parameter int NumRdPorts = DefNumRdPorts,
    parameter int RegRead    = 0
) (
    input logic            clk_i,
    input logic            rst_ni,
    reg_file_mwmr_if.slave bus
);

    localparam int NumRegsWidth = $clog2(NumRegs);

    logic [NumRegs-1:0][DataWidth-1:0]    regs;
    logic [NumRegs-1:0]                   vld;
    logic [NumRegs-1:0]                   we;
    logic [NumRegs-1:0][DataWidth-1:0]    wdata;
    logic [NumRdPorts-1:0][DataWidth-1:0] rd_d;
    logic [NumRdPorts-1:0]                rd_v;
    wr_req_t                              req [NumWrPorts];

    // Out-of-range write addresses are dropped here, before selection.
    always_comb begin
        for (int p = 0; p < NumWrPorts; p++) begin
            req[p].en   = bus.wr_en_i[p] &&
                          (int'(bus.wr_addr_i[p]) < NumRegs);
            req[p].addr = MaxAddrW'(bus.wr_addr_i[p]);
            req[p].data = MaxDataW'(bus.wr_data_i[p]);
        end
    end

    reg_file_wr_sel #(
        .DataWidth  (DataWidth),
        .NumRegs    (NumRegs),
        .NumWrPorts (NumWrPorts)
    ) u_wr_sel (
        .req   (req),
        .we    (we),
        .wdata (wdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs <= '0;
            vld  <= '0;
        end else if (bus.clr_i) begin
            regs <= '0;
            vld  <= '0;
        end else begin
            for (int r = 0; r < NumRegs; r++) begin
                if (we[r]) begin
                    regs[r] <= wdata[r];
                    vld[r]  <= 1'b1;
                end
            end
        end
    end

    always_comb begin : rd
        logic [NumRegsWidth-1:0] a;
`ifdef REG_FILE_WR_BYPASS_EN
        logic [MaxPorts-1:0]     hits;
        int                      w;
`endif
        rd_d = '0;
        rd_v = '0;
        for (int q = 0; q < NumRdPorts; q++) begin
            a = bus.rd_addr_i[q];
            if (int'(a) < NumRegs) begin
                rd_d[q] = regs[a];
                rd_v[q] = vld[a];
            end
`ifdef REG_FILE_WR_BYPASS_EN
            hits = '0;
            for (int p = 0; p < NumWrPorts; p++) begin
                hits[p] = req[p].en && (req[p].addr == MaxAddrW'(a));
            end
            w = win_port(hits);
            for (int p = 0; p < NumWrPorts; p++) begin
                if (p == w && !bus.clr_i) begin
                    rd_d[q] = req[p].data[DataWidth-1:0];
                    rd_v[q] = 1'b1;
                end
            end
`endif
        end
    end

    assign bus.valid_o = vld;

    if (RegRead != 0) begin : g_reg_rd
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                bus.rd_data_o  <= '0;
                bus.rd_valid_o <= '0;
            end else if (bus.clr_i) begin
                bus.rd_data_o  <= '0;
                bus.rd_valid_o <= '0;
            end else begin
                bus.rd_data_o  <= rd_d;
                bus.rd_valid_o <= rd_v;
            end
        end
    end else begin : g_comb_rd
        assign bus.rd_data_o  = rd_d;
        assign bus.rd_valid_o = rd_v;
    end

endmodule
